// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with redirect priority, stall-time
// pending redirect and a circular return-address stack.
//   Clk, Reset (async, active-low)
//   PCWrite            advance enable (0 = stall)
//   Exception          redirect to EXC_VECTOR, honoured even while stalled
//   Branch/BranchTarget, Jump/JumpTarget   redirect requests (Branch wins)
//   Call/RetAddr       push a return address
//   Return             pop the RAS and fetch from the popped address
//   PCResult           registered fetch PC;  PCPlusInc = PCResult + INC
//   Pending            a redirect was latched during a stall
//   RasEmpty/RasFull   RAS occupancy flags
//   RasUnderflow       one-cycle pulse after a Return on an empty RAS
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h8000_0180,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             Exception,
    input  logic             Branch,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic [WIDTH-1:0] RetAddr,
    input  logic             Return,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlusInc,
    output logic             Pending,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasUnderflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             uf_q, uf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic             redirect;
    logic [WIDTH-1:0] new_tgt;
    logic [PW-1:0]    top_inc;

    assign redirect     = Branch | Jump;
    assign new_tgt      = Branch ? BranchTarget : JumpTarget;
    assign top_inc      = top_q + PW'(1);
    assign PCResult     = pc_q;
    assign PCPlusInc    = pc_q + WIDTH'(INC);
    assign Pending      = pending_q;
    assign RasEmpty     = cnt_q == '0;
    assign RasFull      = cnt_q == CW'(RAS_DEPTH);
    assign RasUnderflow = uf_q;

    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        tgt_d     = tgt_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        uf_d      = 1'b0;
        ras_d     = ras_q;
        if (Exception) begin
            pc_d      = EXC_VECTOR;
            pending_d = 1'b0;
        end else if (!PCWrite) begin
            if (redirect) begin
                pending_d = 1'b1;
                tgt_d     = new_tgt;
            end
        end else begin
            pending_d = 1'b0;
            if (redirect)
                pc_d = new_tgt;
            else if (pending_q)
                pc_d = tgt_q;
            else begin
                pc_d = PCPlusInc;
                if (Return && !RasEmpty) begin
                    pc_d = ras_q[top_q];
                    // Call+Return swaps the top slot in place: count is unchanged
                    if (Call)
                        ras_d[top_q] = RetAddr;
                    else begin
                        top_d = top_q - PW'(1);
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    uf_d = Return;
                    // Push; when full the pointer wraps onto the oldest entry
                    if (Call) begin
                        top_d          = top_inc;
                        ras_d[top_inc] = RetAddr;
                        cnt_d          = RasFull ? cnt_q : cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q      <= RESET_VECTOR;
            pending_q <= 1'b0;
            tgt_q     <= '0;
            top_q     <= '0;
            cnt_q     <= '0;
            uf_q      <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
            tgt_q     <= tgt_d;
            top_q     <= top_d;
            cnt_q     <= cnt_d;
            uf_q      <= uf_d;
        end
    end

    // Stack contents need no reset; writes are blocked while reset is held
    always_ff @(posedge Clk) begin
        if (Reset)
            ras_q <= ras_d;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus against a queue-based
// reference model of pc_sequencer with default parameters.
module tb_pc_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        PCWrite = 1'b0, Exception = 1'b0, Branch = 1'b0, Jump = 1'b0;
    logic        Call = 1'b0, Return = 1'b0;
    logic [31:0] BranchTarget = '0, JumpTarget = '0, RetAddr = '0;
    logic [31:0] PCResult, PCPlusInc;
    logic        Pending, RasEmpty, RasFull, RasUnderflow;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_tgt;
    logic        m_pend, m_uf;
    logic [31:0] m_ras [$];

    always #5 Clk = ~Clk;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .Exception(Exception),
        .Branch(Branch), .BranchTarget(BranchTarget), .Jump(Jump),
        .JumpTarget(JumpTarget), .Call(Call), .RetAddr(RetAddr), .Return(Return),
        .PCResult(PCResult), .PCPlusInc(PCPlusInc), .Pending(Pending),
        .RasEmpty(RasEmpty), .RasFull(RasFull), .RasUnderflow(RasUnderflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_tgt  = 32'h0;
        m_pend = 1'b0;
        m_uf   = 1'b0;
        m_ras.delete();
    endtask

    // Stack modelled as a list: newest at the back, oldest dropped on overflow
    task automatic model_step();
        logic [31:0] nxt;
        m_uf = 1'b0;
        if (Exception) begin
            m_pc   = 32'h8000_0180;
            m_pend = 1'b0;
        end else if (!PCWrite) begin
            if (Branch || Jump) begin
                m_pend = 1'b1;
                m_tgt  = Branch ? BranchTarget : JumpTarget;
            end
        end else begin
            if (Branch) m_pc = BranchTarget;
            else if (Jump) m_pc = JumpTarget;
            else if (m_pend) m_pc = m_tgt;
            else begin
                nxt = m_pc + 32'd4;
                if (Return) begin
                    if (m_ras.size() == 0) m_uf = 1'b1;
                    else nxt = m_ras.pop_back();
                end
                if (Call) begin
                    m_ras.push_back(RetAddr);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end
                m_pc = nxt;
            end
            m_pend = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, PCResult, m_pc);
        chk({tag, ".pcinc"}, PCPlusInc, m_pc + 32'd4);
        chk({tag, ".pending"}, {31'b0, Pending}, {31'b0, m_pend});
        chk({tag, ".empty"}, {31'b0, RasEmpty}, {31'b0, m_ras.size() == 0});
        chk({tag, ".full"}, {31'b0, RasFull}, {31'b0, m_ras.size() == 4});
        chk({tag, ".uf"}, {31'b0, RasUnderflow}, {31'b0, m_uf});
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        Exception = 1'b0; Branch = 1'b0; Jump = 1'b0; Call = 1'b0; Return = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("por");
        #10 Reset = 1'b1;
        PCWrite = 1'b1;
        for (int i = 0; i < 16; i++) tick("run");
        chk("pc40", PCResult, 32'h40);
        #2 Reset = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst_pc", PCResult, 32'h0);
        #3 Reset = 1'b1;
        tick("rel1"); chk("rel_pc4", PCResult, 32'h4);
        tick("rel2"); chk("rel_pc8", PCResult, 32'h8);
        tick("rel3"); chk("rel_pcc", PCResult, 32'hC);
        tick("to10");
        PCWrite = 1'b0; Branch = 1'b1; BranchTarget = 32'h200;
        tick("stall_br");
        Branch = 1'b0; Jump = 1'b1; JumpTarget = 32'h300;
        tick("stall_jmp");
        Jump = 1'b0;
        tick("stall_hold");
        chk("stall_pc", PCResult, 32'h10);
        chk("stall_pend", {31'b0, Pending}, 32'h1);
        PCWrite = 1'b1;
        tick("unstall");
        chk("unstall_pc", PCResult, 32'h300);
        Call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            RetAddr = 32'h100 + 32'(4 * i);
            tick("call");
        end
        chk("ras_full", {31'b0, RasFull}, 32'h1);
        Call = 1'b0; Return = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("ret");
            chk("ret_pc", PCResult, 32'h110 - 32'(4 * i));
        end
        tick("ret_empty");
        chk("ret_empty_pc", PCResult, 32'h108);
        chk("ret_empty_uf", {31'b0, RasUnderflow}, 32'h1);
        Return = 1'b0;
        tick("uf_clear");
        Call = 1'b1; RetAddr = 32'h44;
        tick("push44");
        Call = 1'b0; PCWrite = 1'b0; Branch = 1'b1; BranchTarget = 32'h700;
        tick("pend_set");
        Branch = 1'b0; Exception = 1'b1;
        tick("exc");
        chk("exc_pc", PCResult, 32'h8000_0180);
        chk("exc_pend", {31'b0, Pending}, 32'h0);
        chk("exc_ras", {31'b0, RasEmpty}, 32'h0);
        Exception = 1'b0; PCWrite = 1'b1; Call = 1'b1; Return = 1'b1; RetAddr = 32'h50;
        tick("callret");
        chk("callret_pc", PCResult, 32'h44);
        Call = 1'b0;
        tick("ret50");
        chk("ret50_pc", PCResult, 32'h50);
        tick("ret_uf");
        chk("ret_uf", {31'b0, RasUnderflow}, 32'h1);
        Return = 1'b0; Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        tick("jmp_top");
        Jump = 1'b0;
        tick("wrap");
        chk("wrap_pc", PCResult, 32'h0);
        chk("wrap_inc", PCPlusInc, 32'h4);
        for (int i = 0; i < 3000; i++) begin
            PCWrite      = $urandom_range(0, 3) != 0;
            Exception    = $urandom_range(0, 19) == 0;
            Branch       = $urandom_range(0, 7) == 0;
            Jump         = $urandom_range(0, 7) == 0;
            Call         = $urandom_range(0, 3) == 0;
            Return       = $urandom_range(0, 3) == 0;
            BranchTarget = $urandom & ~32'h3;
            JumpTarget   = $urandom & ~32'h3;
            RetAddr      = $urandom & ~32'h3;
            tick("rnd");
            if ($urandom_range(0, 299) == 0) begin
                #2 Reset = 1'b0;
                #1 model_reset();
                check_all("rnd_rst");
                #2 Reset = 1'b1;
            end
        end
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
